// File: rtl/up_dn_counter_range.sv
// Up/down counter with programmable step and a [lo, hi] window; over/underflow either
// saturates at the violated limit or wraps inside the window, selected at runtime.
module up_dn_counter_range #(
    parameter int unsigned      WIDTH   = 5,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             up_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0] lo_lim_i,
    input  logic [WIDTH-1:0] hi_lim_i,
    input  logic             wrap_en_i,
    output logic [WIDTH-1:0] counter_o,
    output logic             l_flag_o,
    output logic             h_flag_o,
    output logic             ovf_o,
    output logic             unf_o,
    output logic             cfg_err_o
);

    // Two guard bits: one for carry out of cnt+step, one headroom for intermediate sums.
    localparam int unsigned EW = WIDTH + 2;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [EW-1:0] cnt_x, step_x, lo_x, hi_x, lv_x;
    logic [EW-1:0] span, sum, excess, deficit, nxt_x;
    logic          cfg_err, count_req, down_fits;
    logic          unused_nxt;

    assign cnt_x  = {2'b00, cnt_q};
    assign step_x = {2'b00, step_i};
    assign lo_x   = {2'b00, lo_lim_i};
    assign hi_x   = {2'b00, hi_lim_i};
    assign lv_x   = {2'b00, load_val_i};

    assign cfg_err   = lo_lim_i > hi_lim_i;
    assign count_req = (up_i ^ down_i) && (step_i != '0) && !cfg_err;

    assign span      = hi_x - lo_x + 1'b1;
    assign sum       = cnt_x + step_x;
    assign excess    = sum - hi_x - 1'b1;
    // cnt - step >= lo, rearranged to stay unsigned
    assign down_fits = cnt_x >= (step_x + lo_x);
    assign deficit   = lo_x + step_x - cnt_x - 1'b1;

    always_comb begin
        nxt_x = cnt_x;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (clr_i) begin
            nxt_x = {2'b00, RST_VAL};
        end else if (load_i) begin
            if (cfg_err)             nxt_x = lv_x;
            else if (lv_x < lo_x)    nxt_x = lo_x;
            else if (lv_x > hi_x)    nxt_x = hi_x;
            else                     nxt_x = lv_x;
        end else if (count_req) begin
            if (cnt_x < lo_x) begin
                nxt_x = lo_x;
            end else if (cnt_x > hi_x) begin
                nxt_x = hi_x;
            end else if (up_i) begin
                if (sum <= hi_x) begin
                    nxt_x = sum;
                end else begin
                    ovf_d = 1'b1;
                    if (!wrap_en_i)          nxt_x = hi_x;
                    else if (step_x > span)  nxt_x = lo_x;
                    else                     nxt_x = lo_x + excess;
                end
            end else begin
                if (down_fits) begin
                    nxt_x = cnt_x - step_x;
                end else begin
                    unf_d = 1'b1;
                    if (!wrap_en_i)          nxt_x = lo_x;
                    else if (step_x > span)  nxt_x = hi_x;
                    else                     nxt_x = hi_x - deficit;
                end
            end
        end
        cnt_d = nxt_x[WIDTH-1:0];
    end

    // Every path keeps nxt_x within [0, 2^WIDTH-1], so the guard bits are always zero here.
    assign unused_nxt = ^nxt_x[EW-1:WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign counter_o = cnt_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;
    assign l_flag_o  = cnt_q <= lo_lim_i;
    assign h_flag_o  = cnt_q >= hi_lim_i;
    assign cfg_err_o = cfg_err;

endmodule

// File: tb/tb_up_dn_counter_range.sv
// Bench for up_dn_counter_range: directed scenarios pinned to literals, then random traffic
// compared every cycle against an integer window-arithmetic model.
module tb_up_dn_counter_range;

    localparam int W   = 5;
    localparam int RST = 0;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clr_i, load_i, up_i, down_i, wrap_en_i;
    logic [W-1:0] load_val_i, step_i, lo_lim_i, hi_lim_i;
    logic [W-1:0] counter_o;
    logic         l_flag_o, h_flag_o, ovf_o, unf_o, cfg_err_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state
    int m_cnt = RST;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    up_dn_counter_range #(.WIDTH(W), .RST_VAL(5'(RST))) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .up_i       (up_i),
        .down_i     (down_i),
        .step_i     (step_i),
        .lo_lim_i   (lo_lim_i),
        .hi_lim_i   (hi_lim_i),
        .wrap_en_i  (wrap_en_i),
        .counter_o  (counter_o),
        .l_flag_o   (l_flag_o),
        .h_flag_o   (h_flag_o),
        .ovf_o      (ovf_o),
        .unf_o      (unf_o),
        .cfg_err_o  (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Window arithmetic: positions relative to lo, wrap taken modulo the span.
    task automatic model_update();
        int lo, hi, st, sp, rel;
        lo = int'(lo_lim_i);
        hi = int'(hi_lim_i);
        st = int'(step_i);
        sp = hi - lo + 1;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (!rst_ni) begin
            m_cnt = RST;
        end else if (clr_i) begin
            m_cnt = RST;
        end else if (load_i) begin
            if (lo > hi) m_cnt = int'(load_val_i);
            else         m_cnt = (int'(load_val_i) < lo) ? lo :
                                 (int'(load_val_i) > hi) ? hi : int'(load_val_i);
        end else if ((up_i != down_i) && st != 0 && lo <= hi) begin
            if (m_cnt < lo) begin
                m_cnt = lo;
            end else if (m_cnt > hi) begin
                m_cnt = hi;
            end else if (up_i) begin
                if (m_cnt + st <= hi) begin
                    m_cnt = m_cnt + st;
                end else begin
                    m_ovf = 1'b1;
                    if (!wrap_en_i)   m_cnt = hi;
                    else if (st > sp) m_cnt = lo;
                    else              m_cnt = lo + ((m_cnt - lo + st) % sp);
                end
            end else begin
                if (m_cnt - st >= lo) begin
                    m_cnt = m_cnt - st;
                end else begin
                    m_unf = 1'b1;
                    if (!wrap_en_i)   m_cnt = lo;
                    else if (st > sp) m_cnt = hi;
                    else begin
                        rel = (m_cnt - lo - st) % sp;
                        m_cnt = lo + ((rel + sp) % sp);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit u, input bit d,
                         input int st, input int lo, input int hi, input bit wr);
        clr_i = c; load_i = l; load_val_i = W'(lv); up_i = u; down_i = d;
        step_i = W'(st); lo_lim_i = W'(lo); hi_lim_i = W'(hi); wrap_en_i = wr;
    endtask

    // Pins both DUT and model to a hand-computed value.
    task automatic lit(input string name, input int cnt, input bit o, input bit u);
        check({name, " cnt"}, int'(counter_o), cnt);
        check({name, " ovf"}, int'(ovf_o), int'(o));
        check({name, " unf"}, int'(unf_o), int'(u));
        check({name, " model"}, m_cnt, cnt);
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("cnt", int'(counter_o), m_cnt);
            check("ovf", int'(ovf_o), int'(m_ovf));
            check("unf", int'(unf_o), int'(m_unf));
            check("l_flag", int'(l_flag_o), int'(m_cnt <= int'(lo_lim_i)));
            check("h_flag", int'(h_flag_o), int'(m_cnt >= int'(hi_lim_i)));
            check("cfg_err", int'(cfg_err_o), int'(lo_lim_i > hi_lim_i));
        end
    end

    initial begin
        int lo, hi, a, b;
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 31, 0);
        tick(); tick();
        rst_ni = 1'b1;
        lit("reset", 0, 0, 0);
        chk_en = 1'b1;

        // 1: async reset mid-cycle
        drive(0, 1, 12, 0, 0, 0, 0, 31, 0); tick();
        lit("load12", 12, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 31, 0);
        #2 rst_ni = 1'b0; m_cnt = RST; m_ovf = 0; m_unf = 0;
        #1 lit("async_rst", 0, 0, 0);
        tick();
        rst_ni = 1'b1;
        drive(0, 0, 0, 1, 0, 1, 0, 31, 0); tick();
        lit("up_after_rst", 1, 0, 0);

        // 2: saturate at top
        drive(0, 1, 29, 0, 0, 3, 0, 31, 0); tick();
        drive(0, 0, 0, 1, 0, 3, 0, 31, 0); tick();
        lit("sat_up1", 31, 1, 0);
        tick();
        lit("sat_up2", 31, 1, 0);
        check("sat h_flag", int'(h_flag_o), 1);

        // 3: wrap in [4,20]
        drive(0, 1, 5, 0, 0, 3, 4, 20, 1); tick();
        drive(0, 0, 0, 0, 1, 3, 4, 20, 1); tick();
        lit("wrap_dn", 19, 0, 1);
        drive(0, 0, 0, 1, 0, 3, 4, 20, 1); tick();
        lit("wrap_up", 5, 1, 0);
        drive(0, 1, 17, 0, 0, 3, 4, 20, 1); tick();
        drive(0, 0, 0, 1, 0, 3, 4, 20, 1); tick();
        lit("up_to_hi", 20, 0, 0);

        // 4: priorities
        drive(0, 0, 0, 1, 1, 3, 4, 20, 1); tick();
        lit("both_hold", 20, 0, 0);
        drive(0, 1, 9, 1, 0, 3, 4, 20, 1); tick();
        lit("load_over_up", 9, 0, 0);
        drive(1, 1, 9, 0, 0, 3, 4, 20, 1); tick();
        lit("clr_over_load", 0, 0, 0);

        // 5: load clamping
        drive(0, 1, 25, 0, 0, 0, 4, 20, 0); tick();
        lit("load_clamp_hi", 20, 0, 0);
        check("clamp h_flag", int'(h_flag_o), 1);
        drive(0, 1, 2, 0, 0, 0, 4, 20, 0); tick();
        lit("load_clamp_lo", 4, 0, 0);
        check("clamp l_flag", int'(l_flag_o), 1);

        // 6: config error, out-of-window force
        drive(0, 1, 12, 0, 0, 0, 0, 31, 0); tick();
        drive(0, 0, 0, 1, 0, 2, 10, 5, 0); #1;
        check("cfg_err", int'(cfg_err_o), 1);
        tick();
        lit("cfg_up_hold", 12, 0, 0);
        drive(0, 0, 0, 0, 1, 2, 10, 5, 0); tick();
        lit("cfg_dn_hold", 12, 0, 0);
        drive(0, 0, 0, 1, 0, 2, 20, 25, 0); tick();
        lit("force_lo", 20, 0, 0);

        // degenerate window: every nonzero step pulses, counter stays
        drive(0, 1, 7, 0, 0, 0, 7, 7, 1); tick();
        drive(0, 0, 0, 1, 0, 4, 7, 7, 1); tick();
        lit("lo_eq_hi_up", 7, 1, 0);
        drive(0, 0, 0, 0, 1, 4, 7, 7, 0); tick();
        lit("lo_eq_hi_dn", 7, 0, 1);

        // random traffic
        lo = 3; hi = 27;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                a = $urandom_range(0, 31);
                b = $urandom_range(0, 31);
                if ($urandom_range(0, 9) == 0) begin lo = a; hi = b; end
                else begin lo = (a < b) ? a : b; hi = (a < b) ? b : a; end
            end
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6),
                  lo, hi, $urandom_range(0, 1));
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
